// File: rtl/vga_input_conditioner.sv
// Button/switch front end for vgadriver: 2-flop sync, per-button debounce and press pulse.
// Optional auto-repeat on direction buttons [2..5] when VGA_BTN_AUTOREPEAT_EN is defined.
module vga_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic [5:0] btn_in,
  input  logic [2:0] sw_in,
  output logic [5:0] btn_level,
  output logic [5:0] btn_pulse,
  output logic [2:0] sw_out
);

  localparam logic [CNT_W-1:0] DbMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Repeat reload arithmetic below assumes REPEAT_PERIOD <= REPEAT_DELAY.
  if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
      REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
    $error("vga_input_conditioner: illegal parameter combination");
  end

  logic [5:0]       btn_s1_q, btn_s2_q;
  logic [2:0]       sw_s1_q;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic [5:0]       level_d, pulse_d;

`ifdef VGA_BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RptFire   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RptReload = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  // Hold counters for direction channels only; index j maps to button j+2.
  logic [RPT_W-1:0] hold_q [4];
  logic [RPT_W-1:0] hold_d [4];
`endif

  always_comb begin
    level_d = btn_level;
    pulse_d = '0;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != btn_level[i]) begin
        if (cnt_q[i] == DbMax) begin
          level_d[i] = btn_s2_q[i];
          pulse_d[i] = btn_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
`ifdef VGA_BTN_AUTOREPEAT_EN
    for (int j = 0; j < 4; j++) begin
      hold_d[j] = '0;
      // Counts only while the level was already high and stays high; the rising
      // edge itself leaves the counter at zero.
      if (btn_level[j+2] && level_d[j+2]) begin
        if (hold_q[j] == RptFire) begin
          pulse_d[j+2] = 1'b1;
          hold_d[j]    = RptReload;
        end else begin
          hold_d[j] = hold_q[j] + RPT_W'(1);
        end
      end
    end
`endif
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      sw_s1_q   <= '0;
      sw_out    <= '0;
      btn_level <= '0;
      btn_pulse <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
`ifdef VGA_BTN_AUTOREPEAT_EN
      for (int j = 0; j < 4; j++) hold_q[j] <= '0;
`endif
    end else begin
      btn_s1_q  <= btn_in;
      btn_s2_q  <= btn_s1_q;
      sw_s1_q   <= sw_in;
      sw_out    <= sw_s1_q;
      btn_level <= level_d;
      btn_pulse <= pulse_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
`ifdef VGA_BTN_AUTOREPEAT_EN
      for (int j = 0; j < 4; j++) hold_q[j] <= hold_d[j];
`endif
    end
  end

endmodule

// File: tb/tb_vga_input_conditioner.sv
// Scoreboard bench for vga_input_conditioner: expected pulses queued by stimulus,
// popped by a negedge monitor whenever btn_pulse is non-zero.
module tb_vga_input_conditioner;

  logic       sysclk = 1'b0;
  logic       reset_n;
  logic [5:0] btn_in;
  logic [2:0] sw_in;
  logic [5:0] btn_level;
  logic [5:0] btn_pulse;
  logic [2:0] sw_out;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  typedef struct {
    int         at_edge;
    logic [5:0] val;
  } exp_t;
  exp_t exp_q[$];

  vga_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .btn_in   (btn_in),
    .sw_in    (sw_in),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .sw_out   (sw_out)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Press applied between edge base and base+1, released after edge base+hold.
  task automatic push_press(input logic [5:0] mask, input int base, input int hold);
    exp_t e;
    e.at_edge = base + 6;
    e.val     = mask;
    exp_q.push_back(e);
`ifdef VGA_BTN_AUTOREPEAT_EN
    if ((mask & 6'b111100) != 6'b0) begin
      for (int r = base + 16; r <= base + hold + 5; r += 3) begin
        e.at_edge = r;
        e.val     = mask & 6'b111100;
        exp_q.push_back(e);
      end
    end
`endif
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected pulses never seen, next due at edge %0d", name,
               exp_q.size(), exp_q[0].at_edge);
      exp_q.delete();
    end
  endtask

  always @(negedge sysclk) begin
    if (reset_n === 1'b1 && btn_pulse !== 6'b0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got %b expected none (edge %0d)", btn_pulse, edge_n);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.at_edge != edge_n || e.val !== btn_pulse) begin
          fails++;
          $display("FAIL pulse: got %b at edge %0d expected %b at edge %0d", btn_pulse,
                   edge_n, e.val, e.at_edge);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset_n = 1'b0;
    btn_in  = '0;
    sw_in   = '0;
    #3;
    check("reset_level", btn_level, 6'b0);
    check("reset_pulse", btn_pulse, 6'b0);
    check("reset_sw", {3'b0, sw_out}, 6'b0);
    @(negedge sysclk);
    reset_n = 1'b1;
    wait_edges(3);

    // Clean press of North, long hold, then release.
    base   = edge_n;
    btn_in = 6'b010000;
    push_press(6'b010000, base, 26);
    wait_edges(5);
    check("press_before_latency", btn_level, 6'b0);
    wait_edges(1);
    check("press_level", btn_level, 6'b010000);
    wait_edges(20);
    btn_in = 6'b0;
    wait_edges(5);
    check("release_before_latency", btn_level, 6'b010000);
    wait_edges(1);
    check("release_level", btn_level, 6'b0);
    wait_edges(4);
    check_drained("press_release_pulses");

    // Three-cycle glitch on East is rejected.
    btn_in = 6'b000100;
    wait_edges(3);
    btn_in = 6'b0;
    wait_edges(3);
    check("glitch_level_mid", btn_level, 6'b0);
    wait_edges(10);
    check("glitch_level_end", btn_level, 6'b0);

    // Simultaneous change_button and South.
    base   = edge_n;
    btn_in = 6'b100001;
    push_press(6'b100001, base, 10);
    wait_edges(6);
    check("simul_level", btn_level, 6'b100001);
    wait_edges(4);
    btn_in = 6'b0;
    wait_edges(10);
    check("simul_release_level", btn_level, 6'b0);
    check_drained("simul_pulses");

    // Switch synchroniser latency.
    sw_in = 3'b101;
    wait_edges(1);
    check("sw_after_1", {3'b0, sw_out}, 6'b0);
    wait_edges(1);
    check("sw_after_2", {3'b0, sw_out}, 6'b000101);

    // Reset after two debounce counts with set held.
    btn_in = 6'b000010;
    wait_edges(4);
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset_sw", {3'b0, sw_out}, 6'b0);
    check("midreset_level", btn_level, 6'b0);
    check("midreset_pulse", btn_pulse, 6'b0);
    @(negedge sysclk);
    reset_n = 1'b1;
    base    = edge_n;
    push_press(6'b000010, base, 8);
    wait_edges(5);
    check("postreset_before", btn_level, 6'b0);
    wait_edges(1);
    check("postreset_level", btn_level, 6'b000010);
    wait_edges(2);
    btn_in = 6'b0;
    wait_edges(10);
    check("postreset_release", btn_level, 6'b0);
    check_drained("postreset_pulses");

`ifdef VGA_BTN_AUTOREPEAT_EN
    // West held: press pulse then repeats 10, 13, 16 cycles later.
    base   = edge_n;
    btn_in = 6'b001000;
    push_press(6'b001000, base, 17);
    wait_edges(17);
    btn_in = 6'b0;
    wait_edges(10);
    check("repeat_release_level", btn_level, 6'b0);
    check_drained("repeat_pulses");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
